// File: rtl/gate_pattern_checker_if.sv
// Stimulus/response bundle between the pattern checker, the gate under test
// and whoever starts runs and reads the results.
interface gate_pattern_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic [1:0]       op_sel;
  logic             c;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       fail_vec;

  modport master (
    input  start, op_sel, c,
    output a, b, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    output start, op_sel, c,
    input  a, b, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/gate_pattern_checker.sv
// Drives an exhaustive a/b sweep into a 2-input gate, samples its c output
// after a settle time and accumulates mismatches against the selected op.
module gate_pattern_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_pattern_checker_if.master bus
);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       PASS_LAST   = 8'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

  function automatic logic expected_c(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_ONE;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_d     = fail_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d       = bus.op_sel;
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          pass_cnt_d = '0;
          settle_d   = '0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          busy_d     = 1'b1;
          state_d    = APPLY;
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) state_d = CHECK;
        else                         settle_d = settle_q + 4'd1;
      end
      CHECK: begin
        if (bus.c != expected_c(op_q, a_q, b_q)) begin
          err_d         = sat_inc(err_q);
          fail_d[idx_q] = 1'b1;
        end
        // a/b move together with the state so the new pattern starts exactly on APPLY entry
        if (idx_q != 2'd3) begin
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
          settle_d   = '0;
          state_d    = APPLY;
        end else if (pass_cnt_q != PASS_LAST) begin
          idx_d      = '0;
          {a_d, b_d} = 2'b00;
          pass_cnt_d = pass_cnt_q + 8'd1;
          settle_d   = '0;
          state_d    = APPLY;
        end else begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_d == 4'b0000);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      pass_cnt_q <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
    end
    op_q <= op_d;
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vec = fail_q;
endmodule

// File: tb/tb_gate_pattern_checker.sv
// Directed bench: four checker instances (defaults, two passes, 3-bit error
// counter, single settle cycle), each wired to a behavioural 2-input AND gate.
module tb_gate_pattern_checker;
  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  start_v;
  logic [1:0]  op_v [4];
  logic [3:0]  a_v, b_v, busy_v, done_v, pass_v;
  logic [31:0] err_v [4];
  logic [3:0]  fail_v [4];

  gate_pattern_checker_if #(.ERR_W(8)) if0 ();
  gate_pattern_checker_if #(.ERR_W(8)) if1 ();
  gate_pattern_checker_if #(.ERR_W(3)) if2 ();
  gate_pattern_checker_if #(.ERR_W(8)) if3 ();

  gate_pattern_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(8))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  gate_pattern_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_W(8))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  gate_pattern_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_W(3))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
  gate_pattern_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .ERR_W(8))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));

  // and_gate_p stand-in for every instance
  assign if0.c = if0.a & if0.b;
  assign if1.c = if1.a & if1.b;
  assign if2.c = if2.a & if2.b;
  assign if3.c = if3.a & if3.b;

  assign if0.start = start_v[0];  assign if0.op_sel = op_v[0];
  assign if1.start = start_v[1];  assign if1.op_sel = op_v[1];
  assign if2.start = start_v[2];  assign if2.op_sel = op_v[2];
  assign if3.start = start_v[3];  assign if3.op_sel = op_v[3];

  assign a_v[0] = if0.a;  assign b_v[0] = if0.b;  assign busy_v[0] = if0.busy;
  assign a_v[1] = if1.a;  assign b_v[1] = if1.b;  assign busy_v[1] = if1.busy;
  assign a_v[2] = if2.a;  assign b_v[2] = if2.b;  assign busy_v[2] = if2.busy;
  assign a_v[3] = if3.a;  assign b_v[3] = if3.b;  assign busy_v[3] = if3.busy;
  assign done_v[0] = if0.done;  assign pass_v[0] = if0.pass;  assign fail_v[0] = if0.fail_vec;
  assign done_v[1] = if1.done;  assign pass_v[1] = if1.pass;  assign fail_v[1] = if1.fail_vec;
  assign done_v[2] = if2.done;  assign pass_v[2] = if2.pass;  assign fail_v[2] = if2.fail_vec;
  assign done_v[3] = if3.done;  assign pass_v[3] = if3.pass;  assign fail_v[3] = if3.fail_vec;
  assign err_v[0] = {24'd0, if0.err_cnt};
  assign err_v[1] = {24'd0, if1.err_cnt};
  assign err_v[2] = {29'd0, if2.err_cnt};
  assign err_v[3] = {24'd0, if3.err_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run on instance k; n counts edges with the start edge as 1.
  task automatic run(input int k, input logic [1:0] op, input int settle, input int exp_lat,
                     input int exp_err, input logic [3:0] exp_fail, input logic exp_pass,
                     input bit hold);
    int n;
    int pat;
    int bad;
    bad = 0;
    @(negedge clk);
    start_v[k] = 1'b1;
    op_v[k]    = op;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    if (!hold) start_v[k] = 1'b0;
    while (done_v[k] !== 1'b1 && n < 100) begin
      pat = ((n - 1) / (settle + 1)) % 4;
      if (a_v[k] !== pat[1] || b_v[k] !== pat[0] || busy_v[k] !== 1'b1) bad++;
      if (hold)        op_v[k] = ~op_v[k];
      else if (n == 5) start_v[k] = 1'b1;
      else             start_v[k] = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("sweep", bad, 0);
    chk("latency", n, exp_lat);
    chk("done_busy", 32'(busy_v[k]), 0);
    chk("done_ab", 32'({a_v[k], b_v[k]}), 0);
    chk("err_cnt", err_v[k], exp_err);
    chk("fail_vec", 32'(fail_v[k]), 32'(exp_fail));
    chk("pass", 32'(pass_v[k]), 32'(exp_pass));
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", 32'(done_v[k]), 0);
    chk("hold_err", err_v[k], exp_err);
  endtask

  initial begin
    int n;
    int cnt;
    start_v = '0;
    for (int i = 0; i < 4; i++) op_v[i] = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_busy", 32'(busy_v[k]), 0);
      chk("rst_done", 32'(done_v[k]), 0);
      chk("rst_ab", 32'({a_v[k], b_v[k]}), 0);
      chk("rst_err", err_v[k], 0);
      chk("rst_fail", 32'(fail_v[k]), 0);
      chk("rst_pass", 32'(pass_v[k]), 0);
    end

    run(0, 2'b00, 2, 13, 0, 4'b0000, 1'b1, 1'b0);
    run(0, 2'b01, 2, 13, 2, 4'b0110, 1'b0, 1'b0);
    run(0, 2'b11, 2, 13, 4, 4'b1111, 1'b0, 1'b0);
    run(1, 2'b11, 2, 25, 8, 4'b1111, 1'b0, 1'b0);
    run(2, 2'b11, 2, 25, 7, 4'b1111, 1'b0, 1'b0);
    run(3, 2'b00, 1, 9, 0, 4'b0000, 1'b1, 1'b0);
    run(3, 2'b01, 1, 9, 2, 4'b0110, 1'b0, 1'b0);

    // start held high with op_sel toggling; AND latched at the start edge
    run(0, 2'b00, 2, 13, 0, 4'b0000, 1'b1, 1'b1);
    op_v[0] = 2'b10;
    @(posedge clk);
    @(negedge clk);
    chk("retrigger_busy", 32'(busy_v[0]), 1);
    start_v[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[0] === 1'b1) cnt++;
    end
    chk("retrigger_dones", cnt, 1);
    chk("xor_err", err_v[0], 3);
    chk("xor_fail", 32'(fail_v[0]), 32'(4'b1110));
    chk("xor_pass", 32'(pass_v[0]), 0);

    // reset in the middle of the a=1/b=0 pattern, with start asserted at the same edge
    @(negedge clk);
    start_v[0] = 1'b1;
    op_v[0]    = 2'b11;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 1;
    while (!(a_v[0] === 1'b1 && b_v[0] === 1'b0) && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("pre_rst_ab", 32'({a_v[0], b_v[0]}), 32'(2'b10));
    chk("pre_rst_err", err_v[0], 2);
    rst_n      = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    start_v[0] = 1'b0;
    chk("midrst_ab", 32'({a_v[0], b_v[0]}), 0);
    chk("midrst_busy", 32'(busy_v[0]), 0);
    chk("midrst_err", err_v[0], 0);
    chk("midrst_fail", 32'(fail_v[0]), 0);
    chk("midrst_pass", 32'(pass_v[0]), 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("midrst_quiet", cnt, 0);
    run(0, 2'b00, 2, 13, 0, 4'b0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
